// File: rtl/skinny_sbox8_inv_cms_if.sv
// Byte-stream interface of the masked inverse SKINNY S-box.
// en is a global advance; a byte is taken when en && in_valid, and a result is presented while out_valid.
interface skinny_sbox8_inv_cms_if;
  logic       en;
  logic       in_valid;
  logic [7:0] x1;
  logic [7:0] x2;
  logic       out_valid;
  logic [7:0] y1;
  logic [7:0] y2;

  modport master (
    output en, in_valid, x1, x2,
    input  out_valid, y1, y2
  );

  modport slave (
    input  en, in_valid, x1, x2,
    output out_valid, y1, y2
  );
endinterface

// File: rtl/skinny_sbox8_inv_cms.sv
// Two-share CMS-masked SKINNY-128 inverse S-box, four register stages, one byte per enabled cycle.
// Each stage applies a linear remap (Q, then Pinv three times) followed by one masked g.
module skinny_sbox8_inv_cms #(
  parameter bit RESET_DATA = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  skinny_sbox8_inv_cms_if.slave   bus
);

  localparam int NS = 4;

  logic [3:0] r_v;
  logic [7:0] r_s0 [NS];
  logic [7:0] r_s1 [NS];
  logic [1:0] r_c0 [NS];
  logic [1:0] r_c1 [NS];

  logic [7:0] w_d0 [NS];
  logic [7:0] w_d1 [NS];
  logic [7:0] w_u0 [NS];
  logic [7:0] w_u1 [NS];

  function automatic logic [7:0] f_q(input logic [7:0] x);
    return {x[7:3], x[1], x[2], x[0]};
  endfunction

  function automatic logic [7:0] f_pinv(input logic [7:0] y);
    return {y[5], y[4], y[0], y[3], y[1], y[7], y[6], y[2]};
  endfunction

  // Share 0 nonlinear part: t ^ NOR(a,b) on its own share only.
  function automatic logic [7:0] f_g_s0(input logic [7:0] u);
    logic [7:0] r;
    r    = u;
    r[4] = u[4] ^ ~(u[7] | u[6]);
    r[0] = u[0] ^ ~(u[3] | u[2]);
    return r;
  endfunction

  // Share 1 nonlinear part: XNOR(t, NAND(a,b)), i.e. t ^ (a & b).
  function automatic logic [7:0] f_g_s1(input logic [7:0] w);
    logic [7:0] r;
    r    = w;
    r[4] = ~(w[4] ^ ~(w[7] & w[6]));
    r[0] = ~(w[0] ^ ~(w[3] & w[2]));
    return r;
  endfunction

  // Cross terms go to their own registers; index 1 targets bit 4, index 0 targets bit 0.
  function automatic logic [1:0] f_cross0(input logic [7:0] u, input logic [7:0] w);
    return {~(u[7] | ~w[6]), ~(u[3] | ~w[2])};
  endfunction

  function automatic logic [1:0] f_cross1(input logic [7:0] u, input logic [7:0] w);
    return {~(u[6] | ~w[7]), ~(u[2] | ~w[3])};
  endfunction

  // Cross terms are folded into their share only after the stage register.
  always_comb begin
    for (int k = 0; k < NS; k++) begin
      w_d0[k] = r_s0[k] ^ {3'b000, r_c0[k][1], 3'b000, r_c0[k][0]};
      w_d1[k] = r_s1[k] ^ {3'b000, r_c1[k][1], 3'b000, r_c1[k][0]};
    end
  end

  always_comb begin
    w_u0[0] = f_q(bus.x1);
    w_u1[0] = f_q(bus.x2);
    for (int k = 1; k < NS; k++) begin
      w_u0[k] = f_pinv(w_d0[k-1]);
      w_u1[k] = f_pinv(w_d1[k-1]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v <= '0;
      if (RESET_DATA) begin
        for (int k = 0; k < NS; k++) begin
          r_s0[k] <= '0;
          r_s1[k] <= '0;
          r_c0[k] <= '0;
          r_c1[k] <= '0;
        end
      end
    end else if (bus.en) begin
      r_v <= {r_v[2:0], bus.in_valid};
      for (int k = 0; k < NS; k++) begin
        r_s0[k] <= f_g_s0(w_u0[k]);
        r_s1[k] <= f_g_s1(w_u1[k]);
        r_c0[k] <= f_cross0(w_u0[k], w_u1[k]);
        r_c1[k] <= f_cross1(w_u0[k], w_u1[k]);
      end
    end
  end

  assign bus.out_valid = r_v[3];
  assign bus.y1        = w_d0[NS-1];
  assign bus.y2        = w_d1[NS-1];

endmodule

// File: tb/tb_skinny_sbox8_inv_cms.sv
// Bench for the masked inverse SKINNY S-box: hand vectors, exhaustive sweep, stall and reset corners.
module tb_skinny_sbox8_inv_cms;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  skinny_sbox8_inv_cms_if ifc();

  skinny_sbox8_inv_cms #(.RESET_DATA(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  typedef struct {
    logic [7:0] x;
    logic [7:0] exp;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  logic [8:0] exp_q[$];
  logic [8:0] last_out;
  logic [7:0] sinv_tab [256];
  int         run_len;
  int         max_run;
  bit         seen_y1 [256];
  vec_t       tv [9];

  // Forward S-box model; the inverse table is built by inverting it.
  function automatic logic [7:0] m_g(input logic [7:0] x);
    logic [7:0] r;
    r    = x;
    r[4] = x[4] ^ ~(x[7] | x[6]);
    r[0] = x[0] ^ ~(x[3] | x[2]);
    return r;
  endfunction

  function automatic logic [7:0] m_p(input logic [7:0] x);
    return {x[2], x[1], x[7], x[6], x[4], x[0], x[3], x[5]};
  endfunction

  function automatic logic [7:0] m_q(input logic [7:0] x);
    return {x[7:3], x[1], x[2], x[0]};
  endfunction

  function automatic logic [7:0] s_fwd(input logic [7:0] b);
    logic [7:0] y;
    y = b;
    for (int i = 0; i < 3; i++) y = m_p(m_g(y));
    return m_q(m_g(y));
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs with a random share split, then check outputs against the model.
  task automatic cycle(input logic c_en, input logic c_vld, input logic c_rst,
                       input logic [7:0] x, input logic [7:0] exp);
    logic [7:0] r;
    logic [7:0] p1;
    logic [8:0] e;
    r            = 8'($urandom_range(0, 255));
    ifc.en       = c_en;
    ifc.in_valid = c_vld;
    ifc.x1       = r;
    ifc.x2       = x ^ r;
    rst          = c_rst;
    p1           = ifc.y1;
    @(posedge clk);
    #1;
    if (c_rst) begin
      exp_q.delete();
      last_out = '0;
      check("rst_out_valid", 16'(ifc.out_valid), 16'h0);
    end else if (!c_en) begin
      check("stall_out_valid", 16'(ifc.out_valid), 16'(last_out[8]));
      if (last_out[8]) check("stall_result", 16'(ifc.y1 ^ ifc.y2), 16'(last_out[7:0]));
      check("stall_y1_hold", 16'(ifc.y1), 16'(p1));
    end else begin
      exp_q.push_back({c_vld, exp});
      if (exp_q.size() >= 4) begin
        e        = exp_q.pop_front();
        last_out = e;
        check("out_valid", 16'(ifc.out_valid), 16'(e[8]));
        if (e[8]) check("result", 16'(ifc.y1 ^ ifc.y2), 16'(e[7:0]));
      end else begin
        last_out = '0;
        check("out_valid_fill", 16'(ifc.out_valid), 16'h0);
      end
      if (ifc.out_valid) run_len++;
      else run_len = 0;
      if (run_len > max_run) max_run = run_len;
    end
  endtask

  task automatic flush();
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int distinct;
    logic [7:0] b;

    tv[0] = '{8'h65, 8'h00};
    tv[1] = '{8'hFF, 8'hFF};
    tv[2] = '{8'h00, 8'hAC};
    tv[3] = '{8'h4C, 8'h01};
    tv[4] = '{8'h6A, 8'h02};
    tv[5] = '{8'h42, 8'h03};
    tv[6] = '{8'h65, 8'h00};
    tv[7] = '{8'h00, 8'hAC};
    tv[8] = '{8'hFF, 8'hFF};

    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      sinv_tab[s_fwd(b)] = b;
    end

    last_out     = '0;
    run_len      = 0;
    max_run      = 0;
    ifc.en       = 1'b1;
    ifc.in_valid = 1'b0;
    ifc.x1       = '0;
    ifc.x2       = '0;
    rst          = 1'b1;

    // Reset with live random input.
    for (int i = 0; i < 2; i++) cycle(1'b1, 1'b1, 1'b1, 8'($urandom_range(0, 255)), 8'h00);
    check("rst_y1", 16'(ifc.y1), 16'h0);
    check("rst_y2", 16'(ifc.y2), 16'h0);

    // Hand vectors, back-to-back.
    for (int i = 0; i < 9; i++) cycle(1'b1, 1'b1, 1'b0, tv[i].x, tv[i].exp);
    flush();

    // Exhaustive sweep against the inverted forward model.
    run_len = 0;
    max_run = 0;
    for (int i = 0; i < 256; i++) cycle(1'b1, 1'b1, 1'b0, 8'(i), sinv_tab[i]);
    flush();
    check("valid_run_256", 16'(max_run), 16'd256);

    // Stall mid-stream: garbage on the inputs while en=0 must be ignored.
    for (int i = 0; i < 5; i++) begin
      b = 8'($urandom_range(0, 255));
      cycle(1'b1, 1'b1, 1'b0, b, sinv_tab[b]);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b1, 1'b0, 8'($urandom_range(0, 255)), 8'h00);
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom_range(0, 255));
      cycle(1'b1, 1'b1, 1'b0, b, sinv_tab[b]);
    end
    for (int i = 0; i < 2; i++) cycle(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    flush();

    // Reset with two bytes in flight: neither may emerge.
    cycle(1'b1, 1'b1, 1'b0, 8'h12, sinv_tab[8'h12]);
    cycle(1'b1, 1'b1, 1'b0, 8'h34, sinv_tab[8'h34]);
    cycle(1'b1, 1'b1, 1'b1, 8'h56, 8'h00);
    check("midrst_y1", 16'(ifc.y1), 16'h0);
    check("midrst_y2", 16'(ifc.y2), 16'h0);
    for (int i = 0; i < 6; i++) cycle(1'b1, 1'b0, 1'b0, 8'h00, 8'h00);

    // Fixed byte under many random share splits.
    for (int i = 0; i < 256; i++) seen_y1[i] = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      cycle(1'b1, 1'b1, 1'b0, 8'h3C, sinv_tab[8'h3C]);
      if (ifc.out_valid) seen_y1[ifc.y1] = 1'b1;
    end
    flush();
    distinct = 0;
    for (int i = 0; i < 256; i++) if (seen_y1[i]) distinct++;
    check("y1_varies", 16'(distinct >= 2), 16'h1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
